// File: rtl/servo_pkg.sv
// Shared types, default widths and helpers for the servo controller.
// Width helpers let each instance size itself from its own parameters.
package servo_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_SLEW
    } fsm_e;

    localparam int ADC_W_DEF = 12;
    localparam int SPAN_DEF  = 1000;
    localparam int NUM_W_DEF = ADC_W_DEF + $clog2(SPAN_DEF + 1);
    localparam int Q_W_DEF   = $clog2(SPAN_DEF + 1);

    function automatic int calc_num_w(int adc_w, int span);
        return adc_w + $clog2(span + 1);
    endfunction

    function automatic int calc_pulse_w(int frame_us);
        return $clog2(frame_us);
    endfunction

    function automatic int calc_us_w(int frame_us);
        return $clog2(frame_us);
    endfunction

    function automatic int center_pulse(int pmin, int span);
        return pmin + span / 2;
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// A start pulse always (re)loads the operands; done pulses for one cycle.
module serial_divider
    import servo_pkg::*;
#(
    parameter int NUM_W = NUM_W_DEF,
    parameter int DEN_W = ADC_W_DEF,
    parameter int Q_W   = Q_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [Q_W-1:0]   quot
);

    localparam int CNT_W = $clog2(NUM_W);

    logic [NUM_W-1:0] q;
    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] dsr;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic [DEN_W:0]   shifted;

    assign shifted = {rem, q[NUM_W-1]};
    assign quot    = q[Q_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= '0;
            rem  <= '0;
            dsr  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                q   <= num;
                rem <= '0;
                dsr <= den;
                cnt <= '0;
                run <= 1'b1;
            end else if (run) begin
                if (shifted >= {1'b0, dsr}) begin
                    rem <= DEN_W'(shifted - {1'b0, dsr});
                    q   <= {q[NUM_W-2:0], 1'b1};
                end else begin
                    rem <= shifted[DEN_W-1:0];
                    q   <= {q[NUM_W-2:0], 1'b0};
                end
                if (cnt == CNT_W'(NUM_W - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_servo_controller.sv
// N-channel servo driver: calibrated ADC-to-pulse mapping, slew limiting,
// per-channel enable, one shared serial divider time-multiplexed per frame.
module multi_servo_controller
    import servo_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int ADC_W         = 12,
    parameter int CLK_HZ        = 50_000_000,
    parameter int FRAME_US      = 20000,
    parameter int PULSE_MIN_US  = 1000,
    parameter int PULSE_SPAN_US = 1000,
    parameter int ADC_MARGIN    = 50,
    parameter int SLEW_US       = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*ADC_W-1:0] adc_in,
    input  logic [NUM_CH*ADC_W-1:0] cal_min,
    input  logic [NUM_CH*ADC_W-1:0] cal_max,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       servo_pwm,
    output logic                    frame_start,
    output logic [NUM_CH-1:0]       cal_err,
    output logic                    busy
);

    localparam int NUM_W   = calc_num_w(ADC_W, PULSE_SPAN_US);
    localparam int Q_W     = $clog2(PULSE_SPAN_US + 1);
    localparam int PW      = calc_pulse_w(FRAME_US);
    localparam int UW      = calc_us_w(FRAME_US);
    localparam int SW      = PW + 1;
    localparam int AW      = ADC_W + 2;
    localparam int PRE_DIV = CLK_HZ / 1_000_000;
    localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [PW-1:0] CENTER =
        PW'(center_pulse(PULSE_MIN_US, PULSE_SPAN_US));
    localparam logic signed [SW-1:0] SLEW_S = SW'(SLEW_US);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [UW-1:0]    us_cnt;

    logic [ADC_W-1:0] adc_q  [NUM_CH];
    logic [ADC_W-1:0] cmin_q [NUM_CH];
    logic [ADC_W-1:0] cmax_q [NUM_CH];
    logic [NUM_CH-1:0] en_q;

    logic [PW-1:0] pulse_act  [NUM_CH];
    logic [PW-1:0] pulse_next [NUM_CH];

    fsm_e            state;
    fsm_e            nxt;
    logic [CH_W-1:0] ch;
    logic            last;
    logic [Q_W-1:0]  quot;
    logic [Q_W-1:0]  div_q;
    logic            div_start;
    logic            div_done;

    logic signed [AW-1:0] lo;
    logic signed [AW-1:0] hi;
    logic signed [AW-1:0] a_c;
    logic [ADC_W-1:0]     a_off;
    logic                 win_bad;
    logic [NUM_W-1:0]     num;
    logic [ADC_W-1:0]     den;

    logic signed [SW-1:0] tgt;
    logic signed [SW-1:0] slew_d;
    logic signed [SW-1:0] slew_v;
    logic [PW-1:0]        pulse_new;

    // 1 us timebase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (pre_cnt == PRE_W'(PRE_DIV - 1)) begin
            pre_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
            tick    <= 1'b0;
        end
    end

    assign frame_start = tick && (us_cnt == UW'(FRAME_US - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            us_cnt <= '0;
        end else if (frame_start) begin
            us_cnt <= '0;
        end else if (tick) begin
            us_cnt <= us_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                adc_q[i]     <= '0;
                cmin_q[i]    <= '0;
                cmax_q[i]    <= '0;
                pulse_act[i] <= CENTER;
            end
            en_q <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < NUM_CH; i++) begin
                adc_q[i]     <= adc_in[i*ADC_W +: ADC_W];
                cmin_q[i]    <= cal_min[i*ADC_W +: ADC_W];
                cmax_q[i]    <= cal_max[i*ADC_W +: ADC_W];
                pulse_act[i] <= pulse_next[i];
            end
            en_q <= ch_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            servo_pwm <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                servo_pwm[i] <= en_q[i] && (us_cnt < pulse_act[i]);
            end
        end
    end

    // window, clamp and divider operands for the current channel
    always_comb begin
        lo      = AW'(cmin_q[ch]) + AW'(ADC_MARGIN);
        hi      = AW'(cmax_q[ch]) - AW'(ADC_MARGIN);
        win_bad = (hi <= lo);
        a_c     = AW'(adc_q[ch]);
        if (a_c < lo) begin
            a_c = lo;
        end else if (a_c > hi) begin
            a_c = hi;
        end
        a_off = ADC_W'(a_c - lo);
        num   = NUM_W'(a_off) * NUM_W'(PULSE_SPAN_US);
        den   = ADC_W'(hi - lo);
    end

    always_comb begin
        tgt    = SW'(PULSE_MIN_US) + SW'(quot);
        slew_d = tgt - SW'(pulse_act[ch]);
        slew_v = tgt;
        if (SLEW_US > 0) begin
            if (slew_d > SLEW_S) begin
                slew_d = SLEW_S;
            end else if (slew_d < -SLEW_S) begin
                slew_d = -SLEW_S;
            end
            slew_v = SW'(pulse_act[ch]) + slew_d;
        end
        pulse_new = PW'(slew_v);
    end

    assign last = (ch == CH_W'(NUM_CH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        if (frame_start) begin
            nxt = S_LOAD;
        end else begin
            unique case (state)
                S_IDLE: nxt = S_IDLE;
                S_LOAD: nxt = win_bad ? S_SLEW : S_DIV;
                S_DIV:  nxt = div_done ? S_SLEW : S_DIV;
                S_SLEW: nxt = last ? S_IDLE : S_LOAD;
            endcase
        end
    end

    always_comb begin
        div_start = (state == S_LOAD) && !win_bad && !frame_start;
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch      <= '0;
            quot    <= '0;
            cal_err <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pulse_next[i] <= CENTER;
            end
        end else if (frame_start) begin
            ch      <= '0;
            cal_err <= '0;
        end else begin
            unique case (state)
                S_IDLE: ;
                S_LOAD: begin
                    if (win_bad) begin
                        cal_err[ch] <= 1'b1;
                        quot        <= Q_W'(PULSE_SPAN_US / 2);
                    end
                end
                S_DIV: begin
                    if (div_done) begin
                        quot <= div_q;
                    end
                end
                S_SLEW: begin
                    pulse_next[ch] <= pulse_new;
                    if (!last) begin
                        ch <= ch + 1'b1;
                    end
                end
            endcase
        end
    end

    serial_divider #(
        .NUM_W (NUM_W),
        .DEN_W (ADC_W),
        .Q_W   (Q_W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .start (div_start),
        .num   (num),
        .den   (den),
        .done  (div_done),
        .quot  (div_q)
    );

endmodule
